// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / scoreboard block.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/fwd_select.sv
// Per-operand EX-stage forwarding select; EX/MEM wins over MEM/WB, x0 never forwards.
module fwd_select
    import hazard_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic [AW-1:0] ex_mem_rd,
    input  logic          ex_mem_regwrite,
    input  logic [AW-1:0] mem_wb_rd,
    input  logic          mem_wb_regwrite,
    output logic [1:0]    sel
);

    always_comb begin
        sel = FWD_RF;
        if (ex_mem_regwrite && ex_mem_rd != AW'(REG_ZERO) && ex_mem_rd == rs)
            sel = FWD_EX_MEM;
        else if (mem_wb_regwrite && mem_wb_rd != AW'(REG_ZERO) && mem_wb_rd == rs)
            sel = FWD_MEM_WB;
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Forwarding select, load-use / scoreboard stall detection and long-latency
// register scoreboard with a saturating stall counter.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int AW       = $clog2(NUM_REGS),
    parameter int NUM_SRC  = 2,
    parameter int LU_DEPTH = 4,
    parameter int CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic                   id_kill,
    input  logic [NUM_SRC*AW-1:0]  id_rs,
    input  logic [NUM_SRC-1:0]     id_rs_used,
    input  logic [AW-1:0]          id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_is_lu,
    input  logic [NUM_SRC*AW-1:0]  ex_rs,
    input  logic [AW-1:0]          id_ex_rd,
    input  logic                   id_ex_regwrite,
    input  logic                   id_ex_memread,
    input  logic [AW-1:0]          ex_mem_rd,
    input  logic                   ex_mem_regwrite,
    input  logic [AW-1:0]          mem_wb_rd,
    input  logic                   mem_wb_regwrite,
    input  logic                   lu_done,
    input  logic [AW-1:0]          lu_rd,
    output logic [NUM_SRC*2-1:0]   forward,
    output logic                   stall,
    output logic                   lu_issue,
    output logic [NUM_REGS-1:0]    pending,
    output logic                   sb_err,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int OW = $clog2(LU_DEPTH + 1);

    logic [NUM_SRC-1:0][1:0] fwd_raw;
    logic [OW-1:0]           outstanding;
    logic [NUM_REGS-1:0]     pending_nxt;
    logic [AW-1:0]           rs_i;
    logic                    hazard;
    logic                    done_err;
    logic                    done_ok;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
        fwd_select #(.AW(AW)) u_fwd (
            .rs              (ex_rs[g*AW +: AW]),
            .ex_mem_rd       (ex_mem_rd),
            .ex_mem_regwrite (ex_mem_regwrite),
            .mem_wb_rd       (mem_wb_rd),
            .mem_wb_regwrite (mem_wb_regwrite),
            .sel             (fwd_raw[g])
        );
    end

    // Outputs are held quiet while reset is asserted, independent of the clock.
    assign forward = rst_n ? fwd_raw : '0;

    always_comb begin
        hazard = 1'b0;
        rs_i   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            rs_i = id_rs[i*AW +: AW];
            if (id_rs_used[i]) begin
                if (id_ex_memread && id_ex_regwrite &&
                    id_ex_rd != AW'(REG_ZERO) && id_ex_rd == rs_i)
                    hazard = 1'b1;
                if (pending[rs_i])
                    hazard = 1'b1;
            end
        end
        if (id_regwrite && id_rd != AW'(REG_ZERO) && pending[id_rd])
            hazard = 1'b1;
        if (id_is_lu && outstanding == OW'(LU_DEPTH))
            hazard = 1'b1;
    end

    assign stall    = rst_n && id_valid && !id_kill && hazard;
    assign lu_issue = rst_n && id_valid && !id_kill && id_is_lu && id_regwrite && !stall;

    // A bad completion is flagged and otherwise dropped.
    assign done_err = lu_done && (outstanding == '0 ||
                                  (lu_rd != AW'(REG_ZERO) && !pending[lu_rd]));
    assign done_ok  = lu_done && !done_err;

    always_comb begin
        pending_nxt = pending;
        if (lu_issue && id_rd != AW'(REG_ZERO))
            pending_nxt[id_rd] = 1'b1;
        if (done_ok)
            pending_nxt[lu_rd] = 1'b0;
        pending_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            outstanding <= '0;
            sb_err      <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            pending <= pending_nxt;
            case ({lu_issue, done_ok})
                2'b10:   outstanding <= outstanding + OW'(1);
                2'b01:   outstanding <= outstanding - OW'(1);
                default: outstanding <= outstanding;
            endcase
            if (done_err)
                sb_err <= 1'b1;
            if (stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Vector tables, hand sequences and a randomized run checked against a
// behavioural scoreboard model.
module tb_hazard_scoreboard_unit;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int LD = 4;
    localparam int CW = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid, id_kill, id_regwrite, id_is_lu;
    logic [NS*AW-1:0] id_rs, ex_rs;
    logic [NS-1:0] id_rs_used;
    logic [AW-1:0] id_rd, id_ex_rd, ex_mem_rd, mem_wb_rd, lu_rd;
    logic id_ex_regwrite, id_ex_memread, ex_mem_regwrite, mem_wb_regwrite, lu_done;
    logic [NS*2-1:0] forward;
    logic stall, lu_issue, sb_err;
    logic [NR-1:0] pending;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_scoreboard_unit #(.NUM_REGS(NR), .AW(AW), .NUM_SRC(NS), .LU_DEPTH(LD), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_kill(id_kill), .id_rs(id_rs),
        .id_rs_used(id_rs_used), .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_lu(id_is_lu),
        .ex_rs(ex_rs), .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite),
        .id_ex_memread(id_ex_memread), .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite), .lu_done(lu_done),
        .lu_rd(lu_rd), .forward(forward), .stall(stall), .lu_issue(lu_issue),
        .pending(pending), .sb_err(sb_err), .stall_cnt(stall_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    // behavioural model state
    bit [NR-1:0] m_pend;
    int m_out;
    bit m_err;
    int m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NS*2-1:0] m_fwd();
        logic [NS*2-1:0] res = '0;
        int r;
        for (int i = 0; i < NS; i++) begin
            r = int'(ex_rs[i*AW +: AW]);
            if (ex_mem_regwrite && ex_mem_rd != 0 && int'(ex_mem_rd) == r) res[i*2 +: 2] = 2'd2;
            else if (mem_wb_regwrite && mem_wb_rd != 0 && int'(mem_wb_rd) == r) res[i*2 +: 2] = 2'd1;
        end
        return res;
    endfunction

    function automatic bit m_stall();
        bit h = 0;
        int r;
        for (int i = 0; i < NS; i++) begin
            r = int'(id_rs[i*AW +: AW]);
            if (id_rs_used[i] && id_ex_memread && id_ex_regwrite && id_ex_rd != 0 && int'(id_ex_rd) == r) h = 1;
            if (id_rs_used[i] && m_pend[r]) h = 1;
        end
        if (id_regwrite && id_rd != 0 && m_pend[id_rd]) h = 1;
        if (id_is_lu && m_out == LD) h = 1;
        return id_valid && !id_kill && h;
    endfunction

    task automatic idle();
        id_valid = 0; id_kill = 0; id_rs = '0; id_rs_used = '0; id_rd = '0;
        id_regwrite = 0; id_is_lu = 0; ex_rs = '0; id_ex_rd = '0; id_ex_regwrite = 0;
        id_ex_memread = 0; ex_mem_rd = '0; ex_mem_regwrite = 0; mem_wb_rd = '0;
        mem_wb_regwrite = 0; lu_done = 0; lu_rd = '0;
    endtask

    task automatic model_reset();
        m_pend = '0; m_out = 0; m_err = 0; m_cnt = 0;
    endtask

    // Called just after a rising edge with inputs driven; checks, clocks, checks state.
    task automatic cyc();
        bit st, is, ea, eb, ok;
        #1;
        st = m_stall();
        is = id_valid && !id_kill && id_is_lu && id_regwrite && !st;
        chk("stall", stall, st);
        chk("lu_issue", lu_issue, is);
        chk("forward", forward, m_fwd());
        ea = lu_done && m_out == 0;
        eb = lu_done && lu_rd != 0 && !m_pend[lu_rd];
        ok = lu_done && !ea && !eb;
        if (is && id_rd != 0) m_pend[id_rd] = 1;
        if (ok) m_pend[lu_rd] = 0;
        m_pend[0] = 0;
        m_out = m_out + int'(is) - int'(ok);
        if (ea || eb) m_err = 1;
        if (st && m_cnt < CMAX) m_cnt++;
        @(posedge clk); #1;
        chk("pending", pending, m_pend);
        chk("sb_err", sb_err, m_err);
        chk("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        model_reset();
        #3;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic lu_op(input logic [AW-1:0] rd);
        idle(); id_valid = 1; id_is_lu = 1; id_regwrite = 1; id_rd = rd;
    endtask

    typedef struct {
        logic [4:0] rs0, rs1, exm_rd, mwb_rd;
        logic       exm_we, mwb_we;
        logic [3:0] exp;
    } fwd_vec_t;

    typedef struct {
        logic [4:0] ex_rd, rs0, rs1;
        logic       mr, rw, valid, kill;
        logic [1:0] used;
        logic       exp;
    } ld_vec_t;

    fwd_vec_t fv[8];
    ld_vec_t  lv[9];

    initial begin
        int q[$];
        fv[0] = '{1, 2, 1, 1, 1, 1, 4'b0010};
        fv[1] = '{1, 2, 1, 1, 0, 1, 4'b0001};
        fv[2] = '{0, 0, 0, 0, 1, 1, 4'b0000};
        fv[3] = '{3, 4, 4, 3, 1, 1, 4'b1001};
        fv[4] = '{9, 9, 9, 9, 1, 0, 4'b1010};
        fv[5] = '{31, 30, 30, 31, 1, 1, 4'b1001};
        fv[6] = '{6, 6, 7, 6, 1, 1, 4'b0101};
        fv[7] = '{6, 5, 6, 6, 0, 0, 4'b0000};
        lv[0] = '{5, 5, 0, 1, 1, 1, 0, 2'b01, 1};
        lv[1] = '{5, 5, 0, 1, 1, 1, 0, 2'b00, 0};
        lv[2] = '{5, 0, 5, 1, 1, 1, 0, 2'b10, 1};
        lv[3] = '{5, 5, 0, 0, 1, 1, 0, 2'b01, 0};
        lv[4] = '{5, 5, 0, 1, 0, 1, 0, 2'b01, 0};
        lv[5] = '{0, 0, 0, 1, 1, 1, 0, 2'b11, 0};
        lv[6] = '{5, 5, 5, 1, 1, 0, 0, 2'b11, 0};
        lv[7] = '{5, 5, 5, 1, 1, 1, 1, 2'b11, 0};
        lv[8] = '{5, 6, 0, 1, 1, 1, 0, 2'b01, 0};

        // Outputs forced quiet during reset even with active requests.
        idle(); model_reset();
        lu_op(5'd4);
        ex_rs = {5'd0, 5'd1}; ex_mem_rd = 5'd1; ex_mem_regwrite = 1;
        #2;
        chk("rst_lu_issue", lu_issue, 0);
        chk("rst_forward", forward, 0);
        id_ex_memread = 1; id_ex_regwrite = 1; id_ex_rd = 5'd2; id_rs = {5'd0, 5'd2}; id_rs_used = 2'b01;
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_pending", pending, 0);
        chk("rst_sb_err", sb_err, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        do_reset();

        foreach (fv[k]) begin
            idle();
            ex_rs = {fv[k].rs1, fv[k].rs0};
            ex_mem_rd = fv[k].exm_rd; ex_mem_regwrite = fv[k].exm_we;
            mem_wb_rd = fv[k].mwb_rd; mem_wb_regwrite = fv[k].mwb_we;
            #1 chk($sformatf("fwd_vec%0d", k), forward, fv[k].exp);
            cyc();
        end

        foreach (lv[k]) begin
            idle();
            id_ex_rd = lv[k].ex_rd; id_rs = {lv[k].rs1, lv[k].rs0};
            id_ex_memread = lv[k].mr; id_ex_regwrite = lv[k].rw;
            id_valid = lv[k].valid; id_kill = lv[k].kill; id_rs_used = lv[k].used;
            #1 chk($sformatf("ld_vec%0d", k), stall, lv[k].exp);
            cyc();
        end

        // LU to x7, reader waits through the completion cycle.
        do_reset();
        lu_op(5'd7);
        #1 chk("x7_issue", lu_issue, 1);
        cyc();
        chk("x7_pending", pending[7], 1);
        idle(); id_valid = 1; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01; id_regwrite = 1; id_rd = 5'd1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("x7_reader_stall", stall, 1);
            cyc();
        end
        lu_done = 1; lu_rd = 5'd7;
        #1 chk("x7_done_cycle_stall", stall, 1);
        cyc();
        chk("x7_cleared", pending[7], 0);
        lu_done = 0;
        #1 chk("x7_reader_go", stall, 0);
        cyc();

        // Structural limit.
        for (int r = 8; r < 12; r++) begin
            lu_op(AW'(r));
            cyc();
        end
        lu_op(5'd12);
        #1 chk("full_stall", stall, 1);
        chk("full_no_issue", lu_issue, 0);
        cyc();
        lu_done = 1; lu_rd = 5'd8;
        #1 chk("full_stall_with_done", stall, 1);
        cyc();
        lu_op(5'd12);
        #1 chk("after_done_issue", lu_issue, 1);
        cyc();
        idle(); lu_done = 1; lu_rd = 5'd9; cyc();
        lu_op(5'd13); lu_done = 1; lu_rd = 5'd10;
        #1 chk("issue_and_done", lu_issue, 1);
        cyc();
        lu_op(5'd14); cyc();
        lu_op(5'd15);
        #1 chk("count_kept_stall", stall, 1);
        cyc();
        for (int r = 11; r < 15; r++) begin
            idle(); lu_done = 1; lu_rd = AW'(r); cyc();
        end
        chk("drained", pending, 0);

        // Completion with nothing outstanding; error is sticky.
        idle(); lu_done = 1; lu_rd = 5'd0; cyc();
        chk("err_underflow", sb_err, 1);
        idle(); cyc(); cyc();
        chk("err_sticky", sb_err, 1);

        // Killed LU leaves no trace.
        lu_op(5'd20); id_kill = 1;
        #1 chk("kill_no_issue", lu_issue, 0);
        cyc();
        chk("kill_pending", pending[20], 0);

        // Completion to a non-pending register.
        do_reset();
        lu_op(5'd3); cyc();
        idle(); lu_done = 1; lu_rd = 5'd4; cyc();
        chk("err_not_pending", sb_err, 1);
        chk("err_kept_pending", pending[3], 1);

        // Saturation of the stall counter.
        idle(); id_valid = 1; id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
        for (int c = 0; c < 40; c++) cyc();
        chk("cnt_saturated", stall_cnt, CMAX);

        // Asynchronous reset mid-operation.
        do_reset();
        lu_op(5'd3); cyc();
        idle(); lu_done = 1; lu_rd = 5'd9; cyc();
        idle(); id_valid = 1; id_rs = {5'd0, 5'd3}; id_rs_used = 2'b01;
        for (int c = 0; c < 12; c++) cyc();
        chk("pre_rst_cnt", stall_cnt, 12);
        chk("pre_rst_err", sb_err, 1);
        id_ex_memread = 1; id_ex_regwrite = 1; id_ex_rd = 5'd3;
        #2 rst_n = 0;
        #1;
        chk("async_pending", pending, 0);
        chk("async_cnt", stall_cnt, 0);
        chk("async_err", sb_err, 0);
        chk("async_stall", stall, 0);
        do_reset();

        // Randomized run against the model.
        for (int c = 0; c < 600; c++) begin
            idle();
            id_valid = ($urandom_range(0, 3) != 0);
            id_kill = ($urandom_range(0, 7) == 0);
            id_rs = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            id_rs_used = NS'($urandom_range(0, 3));
            id_rd = AW'($urandom_range(0, 15));
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_is_lu = ($urandom_range(0, 9) < 4);
            ex_rs = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
            id_ex_rd = AW'($urandom_range(0, 7));
            id_ex_regwrite = $urandom_range(0, 1) == 1;
            id_ex_memread = $urandom_range(0, 1) == 1;
            ex_mem_rd = AW'($urandom_range(0, 7));
            ex_mem_regwrite = $urandom_range(0, 1) == 1;
            mem_wb_rd = AW'($urandom_range(0, 7));
            mem_wb_regwrite = $urandom_range(0, 1) == 1;
            if (m_out > 0 && $urandom_range(0, 99) < 35) begin
                q = {};
                for (int r = 1; r < NR; r++) if (m_pend[r]) q.push_back(r);
                lu_done = 1;
                lu_rd = (q.size() > 0) ? AW'(q[$urandom_range(0, q.size() - 1)]) : '0;
            end else if ($urandom_range(0, 99) < 2) begin
                lu_done = 1;
                lu_rd = AW'($urandom_range(0, NR - 1));
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
